// File: rtl/buffer_loader.sv
// Packs IN_NUM_OF_SET incoming sets into one bundle and writes it to the input buffer with a single wen pulse.
// Optional macro LOADER_FLUSH_EN adds a flush input that pushes a partially filled bundle.
module buffer_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_OF_SET   = 128,
  parameter int IN_NUM_OF_SET = 16,
  localparam int IDX_W        = $clog2(IN_NUM_OF_SET)
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      s_valid,
  input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]                    s_data,
  output logic                                                      s_ready,
  input  logic                                                      full_flag,
  output logic                                                      wen,
  output logic [IN_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] din,
  output logic [IDX_W-1:0]                                          set_idx,
  output logic [15:0]                                               bundle_cnt
`ifdef LOADER_FLUSH_EN
  ,
  input  logic                                                      flush
`endif
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0] state;
  logic       accept;
  logic       last_slot;
  logic       flush_go;

  assign s_ready   = (state == FILL) && !rst;
  assign wen       = (state == ISSUE) && !full_flag && !rst;
  assign accept    = s_valid && s_ready;
  assign last_slot = (set_idx == IDX_W'(IN_NUM_OF_SET - 1));

`ifdef LOADER_FLUSH_EN
  // A flush with an accept always ends the fill: either slots remain partly used or the bundle just completed.
  assign flush_go = flush && (state == FILL) && (accept || (set_idx != '0));
`else
  assign flush_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      set_idx    <= '0;
      din        <= '0;
      bundle_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            din[set_idx] <= s_data;
            set_idx      <= set_idx + 1'b1;
          end
          if (flush_go) begin
            set_idx <= '0;
            state   <= ISSUE;
          end else if (accept && last_slot) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Clearing din on the write keeps never-filled slots of the next bundle at zero.
          if (wen) begin
            din        <= '0;
            bundle_cnt <= bundle_cnt + 16'd1;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_loader.sv
// Directed self-checking bench for buffer_loader; define LOADER_FLUSH_EN to also exercise the flush path.
module tb_buffer_loader;

  localparam int DW = 32;
  localparam int DS = 128;
  localparam int NS = 16;

  typedef logic [DS-1:0][DW-1:0]         set_t;
  typedef logic [NS-1:0][DS-1:0][DW-1:0] bundle_t;

  logic          clk;
  logic          rst;
  logic          s_valid;
  set_t          s_data;
  logic          s_ready;
  logic          full_flag;
  logic          wen;
  bundle_t       din;
  logic [3:0]    set_idx;
  logic [15:0]   bundle_cnt;
  logic          flush;

  int            checks;
  int            failures;
  bundle_t       exp_din;
  int            exp_slot;
  logic [15:0]   exp_cnt;

  buffer_loader #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .IN_NUM_OF_SET(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .full_flag  (full_flag),
    .wen        (wen),
    .din        (din),
    .set_idx    (set_idx),
`ifdef LOADER_FLUSH_EN
    .bundle_cnt (bundle_cnt),
    .flush      (flush)
`else
    .bundle_cnt (bundle_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic set_t make_set(input int k);
    set_t r;
    for (int w = 0; w < DS; w++) r[w] = DW'(k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_din(input string tag);
    int bad_s;
    int bad_w;
    checks++;
    assert (din === exp_din) else begin
      failures++;
      bad_s = -1;
      bad_w = -1;
      for (int s = 0; s < NS && bad_s < 0; s++)
        for (int w = 0; w < DS && bad_s < 0; w++)
          if (din[s][w] !== exp_din[s][w]) begin
            bad_s = s;
            bad_w = w;
          end
      if (bad_s >= 0)
        $error("FAIL %s slot=%0d word=%0d observed=%0h expected=%0h",
               tag, bad_s, bad_w, din[bad_s][bad_w], exp_din[bad_s][bad_w]);
      else
        $error("FAIL %s din differs from expected bundle", tag);
    end
  endtask

  task automatic send_set(input int k);
    s_valid = 1'b1;
    s_data  = make_set(k);
    #1;
    check_output("s_ready_fill", 32'(s_ready), 32'd1);
    exp_din[exp_slot] = make_set(k);
    exp_slot++;
    step();
  endtask

  task automatic check_issue(input string tag);
    full_flag = 1'b0;
    s_valid   = 1'b0;
    #1;
    check_output({tag, "_wen"}, 32'(wen), 32'd1);
    check_output({tag, "_ready"}, 32'(s_ready), 32'd0);
    check_output({tag, "_idx"}, 32'(set_idx), 32'd0);
    check_din({tag, "_din"});
    step();
    exp_din  = '0;
    exp_slot = 0;
    exp_cnt  = exp_cnt + 16'd1;
    check_output({tag, "_wen_after"}, 32'(wen), 32'd0);
    check_output({tag, "_cnt"}, 32'(bundle_cnt), 32'(exp_cnt));
    check_output({tag, "_ready_after"}, 32'(s_ready), 32'd1);
    check_din({tag, "_din_cleared"});
  endtask

  initial begin
    int sent;
    int bundles;
    clk       = 1'b0;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    full_flag = 1'b0;
    flush     = 1'b0;
    checks    = 0;
    failures  = 0;
    exp_din   = '0;
    exp_slot  = 0;
    exp_cnt   = '0;

    step();
    check_output("rst_wen", 32'(wen), 32'd0);
    check_output("rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("post_rst_ready", 32'(s_ready), 32'd1);
    check_output("post_rst_idx", 32'(set_idx), 32'd0);
    check_output("post_rst_cnt", 32'(bundle_cnt), 32'd0);
    check_din("post_rst_din");

    $display("[TB] back-to-back bundle");
    for (int k = 1; k <= 16; k++) send_set(k);
    check_issue("b2b");

    $display("[TB] backpressure stall");
    for (int k = 1; k <= 16; k++) send_set(k);
    for (int i = 0; i < 5; i++) begin
      full_flag = 1'b1;
      s_valid   = 1'b1;
      s_data    = make_set(99);
      #1;
      check_output("stall_wen", 32'(wen), 32'd0);
      check_output("stall_ready", 32'(s_ready), 32'd0);
      check_din("stall_din");
      step();
    end
    check_issue("stall_release");

    $display("[TB] toggling valid");
    sent    = 0;
    bundles = 0;
    for (int cyc = 0; cyc < 200 && !(sent == 32 && bundles == 2); cyc++) begin
      s_valid = (cyc % 2 == 0) && (sent < 32);
      s_data  = make_set(100 + sent);
      #1;
      if (wen) begin
        check_din("toggle_bundle");
        exp_din  = '0;
        exp_slot = 0;
        exp_cnt  = exp_cnt + 16'd1;
        bundles++;
      end
      if (s_valid && s_ready) begin
        exp_din[exp_slot] = make_set(100 + sent);
        exp_slot++;
        sent++;
      end
      step();
    end
    s_valid = 1'b0;
    check_output("toggle_sent", 32'(sent), 32'd32);
    check_output("toggle_bundles", 32'(bundles), 32'd2);
    check_output("toggle_cnt", 32'(bundle_cnt), 32'(exp_cnt));

    $display("[TB] reset mid-fill");
    for (int k = 200; k < 207; k++) send_set(k);
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    check_output("midrst_wen", 32'(wen), 32'd0);
    check_output("midrst_ready", 32'(s_ready), 32'd0);
    step();
    rst      = 1'b0;
    exp_din  = '0;
    exp_slot = 0;
    exp_cnt  = '0;
    #1;
    check_output("midrst_idx", 32'(set_idx), 32'd0);
    check_output("midrst_cnt", 32'(bundle_cnt), 32'd0);
    check_output("midrst_wen_after", 32'(wen), 32'd0);
    check_din("midrst_din");
    full_flag = 1'b1;
    for (int k = 300; k < 316; k++) send_set(k);
    check_issue("after_rst");

`ifdef LOADER_FLUSH_EN
    $display("[TB] flush partial bundle");
    send_set(5);
    send_set(6);
    send_set(7);
    s_valid = 1'b0;
    flush   = 1'b1;
    #1;
    check_output("flush_req_wen", 32'(wen), 32'd0);
    check_output("flush_req_idx", 32'(set_idx), 32'd3);
    step();
    flush = 1'b0;
    check_issue("flush_partial");
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1;
      #1;
      check_output("flush_idle_wen", 32'(wen), 32'd0);
      check_output("flush_idle_ready", 32'(s_ready), 32'd1);
      check_output("flush_idle_idx", 32'(set_idx), 32'd0);
      step();
    end
    send_set(9);
    flush = 1'b0;
    check_issue("flush_with_accept");
`endif

    $display("[TB] bundle counter wrap");
    force dut.bundle_cnt = 16'hFFFF;
    #1;
    release dut.bundle_cnt;
    #1;
    exp_cnt = 16'hFFFF;
    check_output("wrap_preset", 32'(bundle_cnt), 32'h0000FFFF);
    for (int k = 400; k < 416; k++) send_set(k);
    check_issue("wrap");
    check_output("wrap_zero", 32'(bundle_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_loader.md
# buffer_loader

Producer-side front end of the convolution input buffer. It accepts sets of DATA_OF_SET words one at a time over a valid/ready stream from the memory side, packs IN_NUM_OF_SET of them into a bundle, and writes the bundle into the buffer with a single-cycle `wen` pulse, honouring the buffer's `full_flag` backpressure. It sits directly upstream of `buffer` and drives its `wen`/`din` write port.

## Interface
- DATA_WIDTH, 32, bits per word
- DATA_OF_SET, 128, words per set
- IN_NUM_OF_SET, 16, sets per bundle (power of two, ≥2)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  upstream set valid
- s_data  in  [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  upstream set
- s_ready  out  1  loader accepts a set this cycle
- full_flag  in  1  buffer cannot accept a write
- wen  out  1  bundle write strobe to buffer
- din  out  [IN_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0]  bundle to buffer, registered
- set_idx  out  $clog2(IN_NUM_OF_SET)  next slot to fill
- bundle_cnt  out  16  bundles written, wraps at 65535→0
- flush  in  1  push partial bundle (only with LOADER_FLUSH_EN)

## Operation
- States: FILL, ISSUE.
- FILL: `s_ready`=1. On `s_valid && s_ready`: `din[set_idx] <= s_data`, `set_idx++`. Accept with `set_idx == IN_NUM_OF_SET-1` → `set_idx` wraps to 0, next state ISSUE.
- ISSUE: `s_ready`=0, `din` held. `wen = (state==ISSUE) && !full_flag && !rst` (combinational). When `wen`=1: `din` cleared to 0 at that edge, `bundle_cnt++`, next state FILL. While `full_flag`=1: stay in ISSUE indefinitely, `din` unchanged.
- Slot order: first accepted set → `din[0]`, last → `din[IN_NUM_OF_SET-1]`.
- `din` is all-zero whenever a fill starts; slots not yet written read 0.
- `s_data` is sampled only on an accept; `s_valid` without `s_ready` has no effect.
- Reset (any state, any cycle): state FILL, `set_idx`=0, `din`=0, `bundle_cnt`=0; `wen`=0 and `s_ready`=0 during the reset cycle. `s_ready`=1 from the first cycle after reset.

## Timing
- Last set accepted at edge N → ISSUE during cycle N+1; `wen`=1 in cycle N+1 if `full_flag`=0; buffer samples `din` at edge N+2; `s_ready`=1 again in cycle N+2.
- Peak throughput: IN_NUM_OF_SET accepts + 1 issue cycle per bundle.
- `full_flag` is examined combinationally each ISSUE cycle; a drop to 0 produces `wen` in that same cycle.
- `wen` is never high for two consecutive cycles.
- `full_flag` is ignored in FILL.

## Configuration
- `LOADER_FLUSH_EN` defined: `flush` port present. In FILL with `flush`=1:
  - accept in the same cycle → the set is stored first; state goes to ISSUE if `set_idx` after the store ≠ 0, or on the normal full-bundle rule.
  - no accept and `set_idx` ≠ 0 → ISSUE; unwritten slots remain 0; `set_idx` resets to 0.
  - `set_idx` = 0 and no accept → ignored.
  - `flush` is ignored in ISSUE.
- Not defined: no `flush` port; only complete bundles are written.

## Test plan
- Reset, then 16 back-to-back sets with every word = set number k (1..16), `full_flag`=0 -> `wen` exactly one cycle, one cycle after the 16th accept; `din[k-1]` all words = k; `bundle_cnt`=1; `din`=0 next cycle.
- Same stimulus, `full_flag`=1 for 5 cycles after the 16th accept -> `s_ready`=0 and `wen`=0 for those 5 cycles, `din` stable; `wen` in the cycle `full_flag` falls.
- `s_valid` toggling 1,0,1,0 across 32 sets -> exactly 2 bundles; ordering preserved; no set lost or duplicated.
- Assert `rst` after 7 accepted sets -> `set_idx`=0, `din`=0, no `wen`; a following full 16-set run produces one correct bundle.
- `LOADER_FLUSH_EN`: 3 sets of 5, 6, 7, then `flush` -> `wen` with `din[0..2]` = 5, 6, 7 and `din[3..15]` = 0; `flush` with `set_idx`=0 -> no `wen`.
- Run 65536 bundles (or force `bundle_cnt` to 65535) -> `bundle_cnt` wraps to 0.
